// File: rtl/d_ff_pipe.sv
// Multi-stage valid/ready register pipeline: bubbles collapse, stalls ripple back,
// synchronous flush drops in-flight words while keeping stage data.

module d_ff_pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             acc,
  input  logic             up_vld,
  input  logic [WIDTH-1:0] up_dat,
  output logic             vld_q,
  output logic [WIDTH-1:0] dat_q
);
  logic             vld_d;
  logic [WIDTH-1:0] dat_d;

  // Data only moves together with an accept so a stalled word is never overwritten.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (acc) begin
      vld_d = up_vld;
      if (up_vld) dat_d = up_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= 1'b0;
      dat_q <= RESET_VAL;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end
endmodule

module d_ff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            vld;
  logic [DEPTH-1:0][WIDTH-1:0] dat;
  logic [DEPTH-1:0]            acc;
  logic [DEPTH-1:0]            up_vld;
  logic [DEPTH-1:0][WIDTH-1:0] up_dat;
  logic [OCC_W-1:0]            occ_c;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    // A stage can take a word if any stage from it to the tail is empty, or the tail drains.
    assign acc[i] = out_ready | ~(&vld[DEPTH-1:i]);

    if (i == 0) begin : g_head
      assign up_vld[i] = in_valid;
      assign up_dat[i] = in_data;
    end else begin : g_body
      assign up_vld[i] = vld[i-1];
      assign up_dat[i] = dat[i-1];
    end

    d_ff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stg (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .acc    (acc[i]),
      .up_vld (up_vld[i]),
      .up_dat (up_dat[i]),
      .vld_q  (vld[i]),
      .dat_q  (dat[i])
    );
  end

  always_comb begin
    occ_c = '0;
    for (int i = 0; i < DEPTH; i++) occ_c = occ_c + OCC_W'(vld[i]);
  end

  assign in_ready  = acc[0] & reset & ~flush;
  assign out_valid = vld[DEPTH-1] & ~flush;
  assign out_data  = dat[DEPTH-1];
  assign occupancy = occ_c;
endmodule
